reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Register-hazard controller for the in-order pipeline. It sits beside ID_stage and replaces its ad-hoc reg_lock vector with a counted scoreboard. It decides each cycle whether the decoded instruction may issue to EX, and tracks outstanding writes per architectural register until WB retires them. It also provides a drain/fence sequence and a flush path for the control unit.

Parameters:
NREGS, 32, number of architectural registers (x0 hardwired zero)
CNT_W, 2, width of per-register outstanding-write counter (max 2^CNT_W-1 in flight per reg)
WB_BYPASS, 1, 1 = a WB release in the same cycle satisfies a RAW check

Ports:
clk  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
issue_req_i  in  1  ID has a decoded instruction ready
rs1_i  in  5  source register 1
rs2_i  in  5  source register 2
rs1_used_i  in  1  instruction reads rs1
rs2_used_i  in  1  instruction reads rs2
rd_i  in  5  destination register
rd_used_i  in  1  instruction writes rd
issue_gnt_o  out  1  instruction issues this cycle (combinational)
wb_valid_i  in  1  WB stage writes a register this cycle
wb_rd_i  in  5  register written by WB
flush_i  in  1  pipeline flush; all in-flight writes are discarded
drain_req_i  in  1  fence request: stop issue until nothing is outstanding
drained_o  out  1  pipeline empty of pending writes, fence complete (registered)
busy_o  out  1  any counter non-zero (combinational)
stall_cnt_o  out  32  cycles with issue_req_i=1 and issue_gnt_o=0 (registered)

Behaviour:
- Reset (rst_i=1 at edge): all counters 0, FSM=RUN, drained_o=0, stall_cnt_o=0. rst_i overrides every other input.
- Hazard terms for a source s: pend(s) = cnt[s]!=0 and s!=0. With WB_BYPASS=1 and wb_valid_i and wb_rd_i==s and cnt[s]==1, pend(s)=0.
- raw = (rs1_used_i and pend(rs1_i)) or (rs2_used_i and pend(rs2_i)).
- sat = rd_used_i and rd_i!=0 and cnt[rd_i]==max. The WB release in the same cycle does not clear sat.
- issue_gnt_o = issue_req_i and state==RUN and !flush_i and !raw and !sat. There is no cycle of latency.
- Counter update per register r in one cycle: inc = issue_gnt_o and rd_used_i and rd_i==r and r!=0; dec = wb_valid_i and wb_rd_i==r and r!=0.
  - inc and dec both set: counter is unchanged.
  - dec with counter at 0: counter stays 0. This is an illegal condition; the bench flags it with an assertion, no RTL error output.
- x0 is never counted and never stalls.
- flush_i=1: all counters are cleared next cycle, no grant this cycle, and a WB release this cycle is ignored. The FSM goes to RUN, except that DRAIN moves to DONE because nothing is outstanding after the flush.
- FSM:
  - RUN: drain_req_i=1 goes to DRAIN and blocks issue from that same cycle, because issue is gated by state only from the next cycle. Therefore issue_gnt_o also requires !drain_req_i.
  - DRAIN: no grants. Go to DONE when all counters are 0 after this cycle's update.
  - DONE: drained_o=1. Stay while drain_req_i=1; go to RUN when drain_req_i=0. drained_o deasserts the cycle after leaving DONE.
- stall_cnt_o increments when issue_req_i and !issue_gnt_o, wraps at 2^32, and is cleared only by reset.
- busy_o = OR over all counter!=0.

Decomposition:
- Package core_pkg: typedef reg_idx_t (logic[4:0]), enum sb_state_t {SB_RUN, SB_DRAIN, SB_DONE}, constant NREGS.
- One sub-module sb_counter: a single CNT_W saturating up/down counter with inc, dec, clr, zero and max flags, instantiated NREGS-1 times via generate. The top holds the hazard logic, FSM and stall counter.

Test Plan:
- RAW stall: issue rd=5 (gnt=1), next cycle rs1=5 used -> gnt=0 and stall_cnt_o increments each cycle. WB wb_rd=5 with WB_BYPASS=1 -> gnt=1 that same cycle, cnt[5]=0 afterwards.
- x0: rd=0 issued 10 times, then rs1=0 -> gnt=1 every cycle, busy_o=0.
- Saturation (CNT_W=2): three issues to rd=7 -> cnt=3. Fourth issue to rd=7 -> gnt=0. WB rd=7 -> next cycle grant resumes, cnt=3.
- Simultaneous issue rd=9 and WB wb_rd=9 with cnt[9]=1 -> cnt[9] stays 1. A dec with cnt=0 fires the assertion in the negative test.
- Drain: cnt[3]=1, drain_req_i=1 -> gnt=0 with issue_req_i=1. WB rd=3 -> drained_o=1 next cycle. Drop drain_req_i -> RUN, grants resume one cycle later.
- Flush/reset: cnt[4]=2, cnt[8]=1, flush_i=1 -> no gnt that cycle, busy_o=0 next cycle. Separately, rst_i in DRAIN -> state RUN, drained_o=0, stall_cnt_o=0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared types and constants for the register scoreboard
// Contents: reg_idx_t (architectural register index), sb_state_t (issue FSM
// states), NREGS (architectural register count, x0 included).
package core_pkg;

  localparam int NREGS = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    SB_RUN,
    SB_DRAIN,
    SB_DONE
  } sb_state_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - ID/WB/control-unit bundle seen by the register scoreboard
// master: the pipeline side (ID, WB, control unit) driving requests.
// slave : the scoreboard, returning grant, drained, busy and stall count.
interface reg_scoreboard_if;
  import core_pkg::*;

  logic        issue_req_i;
  reg_idx_t    rs1_i;
  reg_idx_t    rs2_i;
  logic        rs1_used_i;
  logic        rs2_used_i;
  reg_idx_t    rd_i;
  logic        rd_used_i;
  logic        issue_gnt_o;
  logic        wb_valid_i;
  reg_idx_t    wb_rd_i;
  logic        flush_i;
  logic        drain_req_i;
  logic        drained_o;
  logic        busy_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output issue_req_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i, rd_i, rd_used_i,
    output wb_valid_i, wb_rd_i, flush_i, drain_req_i,
    input  issue_gnt_o, drained_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  issue_req_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i, rd_i, rd_used_i,
    input  wb_valid_i, wb_rd_i, flush_i, drain_req_i,
    output issue_gnt_o, drained_o, busy_o, stall_cnt_o
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// rtl/reg_scoreboard_sb_counter.sv - saturating up/down counter of outstanding writes for one register
// Ports: clk, rst (sync, active-high), inc, dec, clr (highest priority after rst),
// cnt (current count), cnt_nxt (value loaded at the next edge), zero, max.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             zero,
  output logic             max
);

  assign zero = (cnt == '0);
  assign max  = &cnt;

  // inc together with dec cancels; a dec at zero is absorbed.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && !dec && !max) begin
      cnt_nxt = cnt + 1'b1;
    end else if (dec && !inc && !zero) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - counted register-hazard scoreboard with drain/fence and flush
// Ports: clk, rst_i (sync, active-high), sb (reg_scoreboard_if.slave): issue
// request/grant with rs1/rs2/rd, WB release, flush, drain request, drained,
// busy and stall counter.
module reg_scoreboard #(
  parameter int NREGS     = core_pkg::NREGS,
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_i,
  reg_scoreboard_if.slave  sb
);
  import core_pkg::*;

  logic [CNT_W-1:0] cnt     [NREGS];
  logic [CNT_W-1:0] cnt_nxt [NREGS];
  logic [NREGS-1:0] zero_v;
  logic [NREGS-1:0] max_v;

  sb_state_t   state;
  logic        drained;
  logic [31:0] stall_cnt;

  logic pend1, pend2, raw, sat, gnt, all_zero_nxt;

  // x0 is never tracked: a constant empty slot keeps the lookups uniform.
  assign cnt[0]     = '0;
  assign cnt_nxt[0] = '0;
  assign zero_v[0]  = 1'b1;
  assign max_v[0]   = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    logic inc, dec;
    assign inc = gnt && sb.rd_used_i && (sb.rd_i == reg_idx_t'(r));
    // A flush discards the WB release along with everything else.
    assign dec = sb.wb_valid_i && (sb.wb_rd_i == reg_idx_t'(r)) && !sb.flush_i;

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst_i),
      .inc     (inc),
      .dec     (dec),
      .clr     (sb.flush_i),
      .cnt     (cnt[r]),
      .cnt_nxt (cnt_nxt[r]),
      .zero    (zero_v[r]),
      .max     (max_v[r])
    );
  end

  always_comb begin
    pend1 = (sb.rs1_i != '0) && !zero_v[sb.rs1_i];
    pend2 = (sb.rs2_i != '0) && !zero_v[sb.rs2_i];
    // Bypass only when this release retires the last outstanding write.
    if (WB_BYPASS && sb.wb_valid_i && (sb.wb_rd_i == sb.rs1_i) && (cnt[sb.rs1_i] == CNT_W'(1)))
      pend1 = 1'b0;
    if (WB_BYPASS && sb.wb_valid_i && (sb.wb_rd_i == sb.rs2_i) && (cnt[sb.rs2_i] == CNT_W'(1)))
      pend2 = 1'b0;
    raw = (sb.rs1_used_i && pend1) || (sb.rs2_used_i && pend2);
    // A same-cycle release does not relieve saturation: the counter is read as-is.
    sat = sb.rd_used_i && (sb.rd_i != '0) && max_v[sb.rd_i];
    // drain_req_i gates directly so the fence holds in the request cycle.
    gnt = sb.issue_req_i && (state == SB_RUN) && !sb.drain_req_i && !sb.flush_i && !raw && !sat;
  end

  always_comb begin
    all_zero_nxt = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      if (cnt_nxt[r] != '0) all_zero_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state     <= SB_RUN;
      drained   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (sb.issue_req_i && !gnt) stall_cnt <= stall_cnt + 32'd1;
      if (sb.flush_i) begin
        // Nothing is outstanding after a flush, so a pending fence completes.
        if (state == SB_DRAIN) begin
          state   <= SB_DONE;
          drained <= 1'b1;
        end else begin
          state   <= SB_RUN;
          drained <= 1'b0;
        end
      end else begin
        case (state)
          SB_RUN: begin
            if (sb.drain_req_i) state <= SB_DRAIN;
          end
          SB_DRAIN: begin
            if (all_zero_nxt) begin
              state   <= SB_DONE;
              drained <= 1'b1;
            end
          end
          SB_DONE: begin
            if (!sb.drain_req_i) begin
              state   <= SB_RUN;
              drained <= 1'b0;
            end
          end
          default: begin
            state   <= SB_RUN;
            drained <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sb.issue_gnt_o = gnt;
  assign sb.drained_o   = drained;
  assign sb.busy_o      = |(~zero_v);
  assign sb.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   illegal_dec = 0;

  always #5 clk = ~clk;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.NREGS(32), .CNT_W(2), .WB_BYPASS(1'b1)) dut (
    .clk   (clk),
    .rst_i (rst),
    .sb    (sb_if)
  );

  // Illegal condition: a WB release to a register with nothing outstanding.
  always @(negedge clk) begin
    if (!rst && sb_if.wb_valid_i && (sb_if.wb_rd_i != 5'd0) && !sb_if.flush_i &&
        dut.zero_v[sb_if.wb_rd_i])
      illegal_dec++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb_if.issue_req_i = 1'b0;
    sb_if.rs1_i       = 5'd0;
    sb_if.rs2_i       = 5'd0;
    sb_if.rs1_used_i  = 1'b0;
    sb_if.rs2_used_i  = 1'b0;
    sb_if.rd_i        = 5'd0;
    sb_if.rd_used_i   = 1'b0;
    sb_if.wb_valid_i  = 1'b0;
    sb_if.wb_rd_i     = 5'd0;
    sb_if.flush_i     = 1'b0;
    sb_if.drain_req_i = 1'b0;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    idle();
    sb_if.issue_req_i = 1'b1;
    sb_if.rd_i        = rd;
    sb_if.rd_used_i   = 1'b1;
  endtask

  task automatic read_rs1(input logic [4:0] rs);
    idle();
    sb_if.issue_req_i = 1'b1;
    sb_if.rs1_i       = rs;
    sb_if.rs1_used_i  = 1'b1;
  endtask

  task automatic wb(input logic [4:0] rd);
    sb_if.wb_valid_i = 1'b1;
    sb_if.wb_rd_i    = rd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    chk("reset_busy", sb_if.busy_o, 0);
    chk("reset_drained", sb_if.drained_o, 0);
    chk("reset_stall", sb_if.stall_cnt_o, 0);
    rst = 1'b0;

    // RAW stall on x5, released by a bypassed WB
    issue_rd(5'd5); settle(); chk("raw_issue_gnt", sb_if.issue_gnt_o, 1); cyc();
    chk("raw_busy", sb_if.busy_o, 1);
    read_rs1(5'd5); settle(); chk("raw_stall_gnt0", sb_if.issue_gnt_o, 0); cyc();
    chk("raw_stall_cnt1", sb_if.stall_cnt_o, 1);
    settle(); chk("raw_stall_gnt1", sb_if.issue_gnt_o, 0); cyc();
    chk("raw_stall_cnt2", sb_if.stall_cnt_o, 2);
    wb(5'd5); settle(); chk("raw_bypass_gnt", sb_if.issue_gnt_o, 1); cyc();
    chk("raw_after_stall", sb_if.stall_cnt_o, 2);
    chk("raw_after_busy", sb_if.busy_o, 0);

    // x0 is neither counted nor stalls
    for (int i = 0; i < 10; i++) begin
      issue_rd(5'd0);
      sb_if.rs1_used_i = 1'b1;
      settle(); chk("x0_gnt", sb_if.issue_gnt_o, 1); cyc();
    end
    chk("x0_busy", sb_if.busy_o, 0);
    chk("x0_stall", sb_if.stall_cnt_o, 2);

    // Saturation of x7 at 3 outstanding writes
    for (int i = 0; i < 3; i++) begin
      issue_rd(5'd7); settle(); chk("sat_fill_gnt", sb_if.issue_gnt_o, 1); cyc();
    end
    issue_rd(5'd7); settle(); chk("sat_block_gnt", sb_if.issue_gnt_o, 0); cyc();
    chk("sat_block_stall", sb_if.stall_cnt_o, 3);
    wb(5'd7); settle(); chk("sat_wb_same_cycle_gnt", sb_if.issue_gnt_o, 0); cyc();
    chk("sat_wb_stall", sb_if.stall_cnt_o, 4);
    issue_rd(5'd7); settle(); chk("sat_resume_gnt", sb_if.issue_gnt_o, 1); cyc();
    issue_rd(5'd7); settle(); chk("sat_full_again_gnt", sb_if.issue_gnt_o, 0); cyc();
    chk("sat_full_stall", sb_if.stall_cnt_o, 5);
    idle(); wb(5'd7); cyc();
    idle(); wb(5'd7); cyc();
    chk("sat_two_left_busy", sb_if.busy_o, 1);
    idle(); wb(5'd7); cyc();
    chk("sat_empty_busy", sb_if.busy_o, 0);

    // Simultaneous inc/dec on x9, then an illegal release at zero
    issue_rd(5'd9); settle(); chk("sim_first_gnt", sb_if.issue_gnt_o, 1); cyc();
    issue_rd(5'd9); wb(5'd9); settle(); chk("sim_both_gnt", sb_if.issue_gnt_o, 1); cyc();
    chk("sim_busy", sb_if.busy_o, 1);
    read_rs1(5'd9); settle(); chk("sim_cnt_held_gnt", sb_if.issue_gnt_o, 0); cyc();
    chk("sim_stall", sb_if.stall_cnt_o, 6);
    idle(); wb(5'd9); cyc();
    chk("sim_release_busy", sb_if.busy_o, 0);
    chk("illegal_none_yet", illegal_dec, 0);
    idle(); wb(5'd9); cyc();
    chk("illegal_dec_flagged", illegal_dec, 1);
    chk("illegal_dec_busy", sb_if.busy_o, 0);
    read_rs1(5'd9); settle(); chk("illegal_dec_gnt", sb_if.issue_gnt_o, 1); cyc();

    // Drain / fence
    issue_rd(5'd3); settle(); chk("drain_issue_gnt", sb_if.issue_gnt_o, 1); cyc();
    idle(); sb_if.issue_req_i = 1'b1; sb_if.drain_req_i = 1'b1;
    settle(); chk("drain_req_gnt", sb_if.issue_gnt_o, 0); cyc();
    chk("drain_wait_drained", sb_if.drained_o, 0);
    chk("drain_stall1", sb_if.stall_cnt_o, 7);
    wb(5'd3); settle(); chk("drain_wb_gnt", sb_if.issue_gnt_o, 0); cyc();
    chk("drain_done", sb_if.drained_o, 1);
    chk("drain_stall2", sb_if.stall_cnt_o, 8);
    idle(); sb_if.issue_req_i = 1'b1;
    settle(); chk("done_release_gnt", sb_if.issue_gnt_o, 0); cyc();
    chk("done_left_drained", sb_if.drained_o, 0);
    chk("done_stall", sb_if.stall_cnt_o, 9);
    settle(); chk("run_resume_gnt", sb_if.issue_gnt_o, 1); cyc();

    // Flush with x4=2, x8=1 outstanding and a WB in the same cycle
    issue_rd(5'd4); cyc();
    issue_rd(5'd4); cyc();
    issue_rd(5'd8); cyc();
    chk("flush_pre_busy", sb_if.busy_o, 1);
    issue_rd(5'd8); wb(5'd4); sb_if.flush_i = 1'b1;
    settle(); chk("flush_gnt", sb_if.issue_gnt_o, 0); cyc();
    chk("flush_busy", sb_if.busy_o, 0);
    chk("flush_stall", sb_if.stall_cnt_o, 10);
    read_rs1(5'd4); sb_if.rs2_i = 5'd8; sb_if.rs2_used_i = 1'b1;
    settle(); chk("flush_after_gnt", sb_if.issue_gnt_o, 1); cyc();

    // Flush while draining completes the fence
    issue_rd(5'd6); cyc();
    idle(); sb_if.drain_req_i = 1'b1; cyc();
    chk("flush_drain_wait", sb_if.drained_o, 0);
    sb_if.flush_i = 1'b1; cyc();
    chk("flush_drain_done", sb_if.drained_o, 1);
    idle(); cyc();
    chk("flush_drain_left", sb_if.drained_o, 0);

    // Reset while in DRAIN
    issue_rd(5'd10); cyc();
    idle(); sb_if.drain_req_i = 1'b1; cyc();
    chk("rst_pre_busy", sb_if.busy_o, 1);
    rst = 1'b1; cyc();
    chk("rst_drained", sb_if.drained_o, 0);
    chk("rst_stall", sb_if.stall_cnt_o, 0);
    chk("rst_busy", sb_if.busy_o, 0);
    rst = 1'b0;
    read_rs1(5'd10); settle(); chk("rst_run_gnt", sb_if.issue_gnt_o, 1); cyc();
    chk("rst_after_stall", sb_if.stall_cnt_o, 0);

    idle();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
